// File: rtl/evs_rd_if.sv
// Cache-line read port between the recipe sequencer and the memory side:
// valid/ready request channel plus an in-order, one-per-request response strobe.
interface evs_rd_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid
  );
endinterface

// File: rtl/evs_recipe_seq.sv
// Eviction-set recipe sequencer: stores CSR-loaded recipe entries, walks them as
// cache-line reads, optionally probes a target and reports latency/hit-miss counts.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_IDLE       | after reset; recipe writes accepted, waiting for op_start
// S_ISSUE      | walk request held on the read port until accepted
// S_WAIT       | walk request outstanding, latency counting
// S_GAP        | op_wait idle cycles after a walk response
// S_PROBE_ISSUE| probe request held on the read port until accepted
// S_PROBE_WAIT | probe outstanding, latency captured into op_timing
// S_DONE       | op_done high, counters frozen until the next command
module evs_recipe_seq #(
  parameter int DEPTH = 256,
  parameter int TMAX  = 1023,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_start,
  input  logic [2:0]        op_params,
  input  logic              op_en_test,
  input  logic [63:0]       op_adr_search,
  input  logic [63:0]       op_adr_target,
  input  logic [9:0]        op_threshold,
  input  logic [7:0]        op_wrap_count,
  input  logic [9:0]        op_wait,
  input  logic [63:0]       op_evs_recipe,
  input  logic              op_evs_recipe_wen,
  input  logic [AW-1:0]     op_evs_addr,
  output logic [63:0]       op_evs_data,
  output logic [63:0]       op_evs_recipe_cnt,
  output logic              op_done,
  output logic [9:0]        op_timing,
  output logic [63:0]       op_debug0,
  evs_rd_if.master          rd
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_PROBE_ISSUE, S_PROBE_WAIT, S_DONE
  } state_t;

  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [9:0]  LAT_MAX = 10'(TMAX);

  logic [63:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [AW:0] idx_q, idx_d;
  logic [7:0]  rep_q, rep_d;
  logic        last_q, last_d;
  logic        probe_q, probe_d;
  logic [9:0]  lat_q, lat_d;
  logic [9:0]  gap_q, gap_d;
  logic [9:0]  timing_q, timing_d;
  logic [31:0] resp_q, resp_d;
  logic [31:0] miss_q, miss_d;
  logic        done_q, done_d;
  logic        req_valid_q, req_valid_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic [63:0] evs_data_q, evs_data_d;

  logic        wr_en;
  logic        start_acc;
  logic        hs;
  logic        rsp_miss;
  logic        advance;
  logic        load_walk;
  logic        load_probe;
  logic [AW:0] run_cnt;
  logic [63:0] walk_entry;
  logic        unused_bits;

  assign wr_en = (state_q == S_IDLE) && op_evs_recipe_wen && (cnt_q < CNT_MAX);

  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt_q[AW-1:0]] <= op_evs_recipe;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rep_d       = rep_q;
    last_d      = last_q;
    probe_d     = probe_q;
    gap_d       = gap_q;
    timing_d    = timing_q;
    resp_d      = resp_q;
    miss_d      = miss_q;
    req_addr_d  = req_addr_q;
    advance     = 1'b0;
    load_walk   = 1'b0;
    load_probe  = 1'b0;
    start_acc   = op_start && ((state_q == S_IDLE) || (state_q == S_DONE));
    hs          = req_valid_q && rd.req_ready;
    run_cnt     = op_params[0] ? '0 : cnt_q;
    rsp_miss    = op_en_test && (lat_q > op_threshold);
    lat_d       = (lat_q == LAT_MAX) ? LAT_MAX : lat_q + 10'd1;

    if (wr_en) cnt_d = cnt_q + 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_acc) begin
          resp_d  = '0;
          miss_d  = '0;
          cnt_d   = run_cnt;
          probe_d = op_params[2];
          idx_d   = '0;
          last_d  = 1'b0;
          rep_d   = (op_wrap_count == 8'd0) ? 8'd0 : op_wrap_count - 8'd1;
          if (op_params[1] && (run_cnt != '0)) begin
            state_d   = S_ISSUE;
            load_walk = 1'b1;
          end else if (op_params[2]) begin
            state_d    = S_PROBE_ISSUE;
            load_probe = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        if (hs) begin
          state_d = S_WAIT;
          lat_d   = 10'd1;
          // Position bookkeeping moves with the accepted request, not the response.
          if (idx_q == cnt_q - 1'b1) begin
            idx_d = '0;
            if (rep_q == 8'd0) last_d = 1'b1;
            else               rep_d  = rep_q - 8'd1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (rd.rsp_valid) begin
          resp_d = resp_q + 32'd1;
          if (rsp_miss) miss_d = miss_q + 32'd1;
          if (op_wait != 10'd0) begin
            state_d = S_GAP;
            gap_d   = op_wait;
          end else begin
            advance = 1'b1;
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q - 10'd1;
        if (gap_q == 10'd1) advance = 1'b1;
      end
      S_PROBE_ISSUE: begin
        if (hs) begin
          state_d = S_PROBE_WAIT;
          lat_d   = 10'd1;
        end
      end
      S_PROBE_WAIT: begin
        if (rd.rsp_valid) begin
          resp_d   = resp_q + 32'd1;
          if (rsp_miss) miss_d = miss_q + 32'd1;
          timing_d = lat_q;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (!last_q) begin
        state_d   = S_ISSUE;
        load_walk = 1'b1;
      end else if (probe_q) begin
        state_d    = S_PROBE_ISSUE;
        load_probe = 1'b1;
      end else begin
        state_d = S_DONE;
      end
    end

    // Address is captured once on entry so it stays stable under back-pressure.
    walk_entry = mem[idx_d[AW-1:0]];
    if (load_walk)  req_addr_d = op_adr_search + {walk_entry[57:0], 6'b0};
    if (load_probe) req_addr_d = {op_adr_target[63:6], 6'b0};

    req_valid_d = (state_d == S_ISSUE) || (state_d == S_PROBE_ISSUE);
    done_d      = (state_d == S_DONE);
    evs_data_d  = ({1'b0, op_evs_addr} < cnt_q) ? mem[op_evs_addr] : '0;
  end

  assign unused_bits = ^{op_adr_target[5:0], walk_entry[63:58]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      rep_q       <= '0;
      last_q      <= 1'b0;
      probe_q     <= 1'b0;
      lat_q       <= '0;
      gap_q       <= '0;
      timing_q    <= '0;
      resp_q      <= '0;
      miss_q      <= '0;
      done_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      evs_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rep_q       <= rep_d;
      last_q      <= last_d;
      probe_q     <= probe_d;
      lat_q       <= lat_d;
      gap_q       <= gap_d;
      timing_q    <= timing_d;
      resp_q      <= resp_d;
      miss_q      <= miss_d;
      done_q      <= done_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      evs_data_q  <= evs_data_d;
    end
  end

  assign op_done           = done_q;
  assign op_timing         = timing_q;
  assign op_debug0         = {miss_q, resp_q};
  assign op_evs_data       = evs_data_q;
  assign op_evs_recipe_cnt = {{(63-AW){1'b0}}, cnt_q};
  assign rd.req_valid      = req_valid_q;
  assign rd.req_addr       = req_addr_q;

endmodule

// File: tb/tb_evs_recipe_seq.sv
// Bench for evs_recipe_seq: table-driven readback, directed corner sequences and
// randomized commands checked against an address/latency reference model.
module tb_evs_recipe_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        op_start;
  logic [2:0]  op_params;
  logic        op_en_test;
  logic [63:0] op_adr_search;
  logic [63:0] op_adr_target;
  logic [9:0]  op_threshold;
  logic [7:0]  op_wrap_count;
  logic [9:0]  op_wait;
  logic [63:0] op_evs_recipe;
  logic        op_evs_recipe_wen;
  logic [7:0]  op_evs_addr;
  logic [63:0] op_evs_data;
  logic [63:0] op_evs_recipe_cnt;
  logic        op_done;
  logic [9:0]  op_timing;
  logic [63:0] op_debug0;

  evs_rd_if rd();

  evs_recipe_seq dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_params(op_params),
    .op_en_test(op_en_test), .op_adr_search(op_adr_search), .op_adr_target(op_adr_target),
    .op_threshold(op_threshold), .op_wrap_count(op_wrap_count), .op_wait(op_wait),
    .op_evs_recipe(op_evs_recipe), .op_evs_recipe_wen(op_evs_recipe_wen),
    .op_evs_addr(op_evs_addr), .op_evs_data(op_evs_data),
    .op_evs_recipe_cnt(op_evs_recipe_cnt), .op_done(op_done), .op_timing(op_timing),
    .op_debug0(op_debug0), .rd(rd)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int mcyc = 0;

  // memory-side responder configuration (written by the main sequence only)
  int rdy_low_req = 0;
  bit rdy_rand = 1'b0;
  int rsp_lat_cfg = 2;
  bit lat_rand = 1'b0;

  // responder-owned logs
  int          cyc = 0;
  int          pend_q[$];
  int          lat_log[$];
  logic [63:0] addr_log[$];
  int          rsp_log[$];
  int          rise_log[$];
  int          hs_log[$];
  int          stab_bad = 0;

  initial begin
    int          low_cnt;
    int          lat;
    logic        prev_v, prev_r, prev_rst;
    logic [63:0] prev_a;
    low_cnt = 0; prev_v = 1'b0; prev_r = 1'b0; prev_rst = 1'b1; prev_a = '0;
    rd.req_ready = 1'b0;
    rd.rsp_valid = 1'b0;
    forever begin
      @(posedge clk); #2;
      cyc++;
      if (prev_v && !prev_r && !prev_rst)
        if (!rd.req_valid || rd.req_addr !== prev_a) stab_bad++;
      rd.rsp_valid = 1'b0;
      if (pend_q.size() > 0 && pend_q[0] <= cyc) begin
        void'(pend_q.pop_front());
        rd.rsp_valid = 1'b1;
        rsp_log.push_back(cyc);
      end
      if (rd.req_valid && !prev_v) rise_log.push_back(cyc);
      rd.req_ready = (low_cnt >= rdy_low_req) && (!rdy_rand || ($urandom_range(0, 1) == 1));
      if (rd.req_valid && !rd.req_ready) low_cnt++;
      if (rd.req_valid && rd.req_ready) begin
        lat = lat_rand ? int'($urandom_range(1, 12)) : rsp_lat_cfg;
        low_cnt = 0;
        hs_log.push_back(cyc);
        addr_log.push_back(rd.req_addr);
        lat_log.push_back(lat);
        pend_q.push_back(cyc + lat);
      end
      prev_v = rd.req_valid; prev_r = rd.req_ready; prev_a = rd.req_addr; prev_rst = reset;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
    mcyc++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic write_entry(input logic [63:0] d);
    op_evs_recipe = d;
    op_evs_recipe_wen = 1'b1;
    tick();
    op_evs_recipe_wen = 1'b0;
  endtask

  task automatic start_op(input logic [2:0] p);
    op_params = p;
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    int i;
    i = 0;
    while (!op_done && i < bound) begin tick(); i++; end
    chk(name, 64'(op_done), 64'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_done"},      64'(op_done), 64'd0);
    chk({tag, "_timing"},    64'(op_timing), 64'd0);
    chk({tag, "_debug0"},    op_debug0, 64'd0);
    chk({tag, "_evs_data"},  op_evs_data, 64'd0);
    chk({tag, "_cnt"},       op_evs_recipe_cnt, 64'd0);
    chk({tag, "_req_valid"}, 64'(rd.req_valid), 64'd0);
    chk({tag, "_req_addr"},  rd.req_addr, 64'd0);
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [63:0] exp;
  } rb_vec_t;

  rb_vec_t rb_tab[7];

  initial begin
    int          a0, r0, s0, h0, l0, m_cnt, m_miss, lt, reps, i;
    logic [9:0]  m_timing;
    logic [2:0]  p;
    logic [63:0] d;
    logic [63:0] rec[$];
    logic [63:0] exp_a[$];

    rb_tab[0] = '{8'd0,   64'h0};
    rb_tab[1] = '{8'd1,   64'h1};
    rb_tab[2] = '{8'd2,   64'h10};
    rb_tab[3] = '{8'd3,   64'h0};
    rb_tab[4] = '{8'd2,   64'h10};
    rb_tab[5] = '{8'd0,   64'h0};
    rb_tab[6] = '{8'd255, 64'h0};

    reset = 1'b1; op_start = 1'b0; op_params = '0; op_en_test = 1'b0;
    op_adr_search = '0; op_adr_target = '0; op_threshold = '0; op_wrap_count = '0;
    op_wait = '0; op_evs_recipe = '0; op_evs_recipe_wen = 1'b0; op_evs_addr = '0;
    tick(); tick(); tick();
    chk_reset_state("reset");
    reset = 1'b0;
    tick();

    // recipe load and registered readback
    write_entry(64'h0); write_entry(64'h1); write_entry(64'h10);
    chk("recipe_cnt3", op_evs_recipe_cnt, 64'd3);
    for (int k = 0; k < 7; k++) begin
      op_evs_addr = rb_tab[k].addr;
      if (k > 0) chk("rb_hold_old", op_evs_data, rb_tab[k-1].exp);
      tick();
      chk($sformatf("rb_addr%0d", rb_tab[k].addr), op_evs_data, rb_tab[k].exp);
    end

    // walk of 3 entries repeated twice
    op_adr_search = 64'h1000; op_wrap_count = 8'd2; rsp_lat_cfg = 2; op_wait = '0;
    a0 = addr_log.size();
    start_op(3'b010);
    wait_done(500, "walk_done");
    chk("walk_nreq", 64'(addr_log.size() - a0), 64'd6);
    exp_a = '{64'h1000, 64'h1040, 64'h1400, 64'h1000, 64'h1040, 64'h1400};
    for (int k = 0; k < 6; k++)
      if (a0 + k < addr_log.size()) chk($sformatf("walk_addr%0d", k), addr_log[a0+k], exp_a[k]);
    chk("walk_debug0", op_debug0, 64'd6);
    if (rsp_log.size() > 0) chk("walk_done_cycle", 64'(mcyc), 64'(rsp_log[$] + 1));

    // probe only, latency 5 above threshold 4
    op_adr_target = 64'h2047; op_threshold = 10'd4; op_en_test = 1'b1; rsp_lat_cfg = 5;
    a0 = addr_log.size();
    start_op(3'b100);
    wait_done(100, "probe_done");
    chk("probe_nreq", 64'(addr_log.size() - a0), 64'd1);
    chk("probe_addr", addr_log[$], 64'h2040);
    chk("probe_timing", 64'(op_timing), 64'd5);
    chk("probe_debug0", op_debug0, {32'd1, 32'd1});

    // latency equal to threshold is not a miss
    rsp_lat_cfg = 4;
    start_op(3'b100);
    wait_done(100, "probe_eq_done");
    chk("probe_eq_timing", 64'(op_timing), 64'd4);
    chk("probe_eq_debug0", op_debug0, {32'd0, 32'd1});

    // back-pressure and latency saturation
    rdy_low_req = 7; rsp_lat_cfg = 1100;
    a0 = addr_log.size();
    start_op(3'b100);
    wait_done(1300, "bp_done");
    chk("bp_nreq", 64'(addr_log.size() - a0), 64'd1);
    chk("bp_addr", addr_log[$], 64'h2040);
    chk("bp_ready_low_cycles", 64'(hs_log[$] - rise_log[$]), 64'd7);
    chk("bp_addr_stable", 64'(stab_bad), 64'd0);
    chk("bp_timing_sat", 64'(op_timing), 64'd1023);
    chk("bp_debug0", op_debug0, {32'd1, 32'd1});
    rdy_low_req = 0;

    // op_start and wen while busy are ignored
    op_wrap_count = 8'd1; rsp_lat_cfg = 4; op_en_test = 1'b0;
    a0 = addr_log.size();
    start_op(3'b010);
    tick(); tick(); tick();
    op_params = 3'b001; op_start = 1'b1;
    op_evs_recipe = 64'hdead; op_evs_recipe_wen = 1'b1;
    tick();
    op_start = 1'b0; op_evs_recipe_wen = 1'b0;
    wait_done(300, "busy_done");
    chk("busy_cnt", op_evs_recipe_cnt, 64'd3);
    chk("busy_nreq", 64'(addr_log.size() - a0), 64'd3);
    chk("busy_debug0", op_debug0, 64'd3);

    // op_wait inserts idle cycles between response and next request
    op_wait = 10'd3; rsp_lat_cfg = 2;
    r0 = rise_log.size(); s0 = rsp_log.size();
    start_op(3'b010);
    wait_done(300, "gap_done");
    chk("gap_nrise", 64'(rise_log.size() - r0), 64'd3);
    for (int k = 1; k < 3; k++)
      if (r0 + k < rise_log.size() && s0 + k - 1 < rsp_log.size())
        chk($sformatf("gap_idle%0d", k), 64'(rise_log[r0+k] - rsp_log[s0+k-1] - 1), 64'd3);
    op_wait = '0;

    // reset while waiting for a response
    rsp_lat_cfg = 10;
    h0 = hs_log.size();
    start_op(3'b010);
    i = 0;
    while (hs_log.size() == h0 && i < 50) begin tick(); i++; end
    chk("rst_hs_seen", 64'(hs_log.size() > h0), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    chk_reset_state("midrst");
    reset = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chk("stale_rsp_debug0", op_debug0, 64'd0);
    chk("stale_rsp_req_valid", 64'(rd.req_valid), 64'd0);
    chk("stale_rsp_done", 64'(op_done), 64'd0);

    // recipe full: entry 257 is dropped
    for (int k = 0; k < 257; k++) write_entry(64'h100 + 64'(k));
    chk("full_cnt", op_evs_recipe_cnt, 64'd256);
    op_evs_addr = 8'd255; tick(); tick();
    chk("full_rb255", op_evs_data, 64'h1ff);
    op_evs_addr = 8'd0; tick(); tick();
    chk("full_rb0", op_evs_data, 64'h100);

    // randomized commands against the reference model
    lat_rand = 1'b1; rdy_rand = 1'b1;
    for (int it = 0; it < 12; it++) begin
      reset = 1'b1; tick(); reset = 1'b0; tick();
      rec.delete();
      m_cnt = int'($urandom_range(0, 5));
      m_timing = '0;
      for (int j = 0; j < m_cnt; j++) begin
        d = {$urandom, $urandom};
        rec.push_back(d);
        write_entry(d);
      end
      for (int c = 0; c < 2; c++) begin
        p = 3'($urandom_range(0, 7));
        p[0] = ($urandom_range(0, 4) == 0);
        op_wrap_count = 8'($urandom_range(0, 2));
        op_wait       = 10'($urandom_range(0, 2));
        op_en_test    = 1'($urandom_range(0, 1));
        op_threshold  = 10'($urandom_range(0, 10));
        op_adr_search = {$urandom, $urandom};
        op_adr_target = {$urandom, $urandom};
        if (p[0]) m_cnt = 0;
        exp_a.delete();
        reps = (op_wrap_count == 0) ? 1 : int'(op_wrap_count);
        if (p[1])
          for (int r = 0; r < reps; r++)
            for (int e = 0; e < m_cnt; e++) exp_a.push_back(op_adr_search + (rec[e] << 6));
        if (p[2]) exp_a.push_back(op_adr_target & ~64'h3f);
        a0 = addr_log.size(); l0 = lat_log.size();
        start_op(p);
        wait_done(3000, "rnd_done");
        chk("rnd_nreq", 64'(addr_log.size() - a0), 64'(exp_a.size()));
        for (int k = 0; k < exp_a.size(); k++)
          if (a0 + k < addr_log.size())
            chk($sformatf("rnd_addr_it%0d_%0d", it, k), addr_log[a0+k], exp_a[k]);
        m_miss = 0;
        for (int k = l0; k < lat_log.size(); k++) begin
          lt = (lat_log[k] > 1023) ? 1023 : lat_log[k];
          if (op_en_test && lt > int'(op_threshold)) m_miss++;
        end
        if (p[2] && lat_log.size() > l0)
          m_timing = 10'((lat_log[$] > 1023) ? 1023 : lat_log[$]);
        chk("rnd_debug0", op_debug0, {32'(m_miss), 32'(exp_a.size())});
        chk("rnd_timing", 64'(op_timing), 64'(m_timing));
        chk("rnd_cnt", op_evs_recipe_cnt, 64'(m_cnt));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
